// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM encoding and expected-data generator modes.
// The write-side generator uses the same constants, so both ends agree on the patterns.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_CHECK = 2'd1;
  localparam logic [1:0] MODE_ADDR  = 2'd2;

endpackage

// File: rtl/bist_exp_gen.sv
// Combinational expected-data generator for the BIST patterns.
// The write path instantiates the same block, so write and read patterns cannot diverge.
module bist_exp_gen
  import bist_pkg::*;
#(
  parameter int ADR_SIZE  = 4,
  parameter int DATA_SIZE = 8
) (
  input  logic [1:0]           mode,
  input  logic [DATA_SIZE-1:0] bg,
  input  logic                 inv,
  input  logic [ADR_SIZE-1:0]  adr,
  output logic [DATA_SIZE-1:0] exp_data
);

  // Wide enough to zero-extend a short address or to truncate a long one.
  localparam int WIDE = (ADR_SIZE > DATA_SIZE) ? ADR_SIZE : DATA_SIZE;

  logic [WIDE-1:0]      adr_wide_s;
  logic [DATA_SIZE-1:0] raw_s;

  assign adr_wide_s = WIDE'(adr);

  // Pattern selection followed by the optional complement; reserved mode reads as solid.
  always_comb begin
    raw_s = bg;
    case (mode)
      MODE_SOLID: raw_s = bg;
      MODE_CHECK: raw_s = bg ^ {DATA_SIZE{adr[0]}};
      MODE_ADDR:  raw_s = adr_wide_s[DATA_SIZE-1:0];
      default:    raw_s = bg;
    endcase
    exp_data = raw_s ^ {DATA_SIZE{inv}};
  end

endmodule

// File: rtl/bist_read_checker.sv
// BIST read-back checker: sweeps the memory in march order, compares each word
// against the generated pattern and reports pass/fail, mismatch count and first failing address.
module bist_read_checker
  import bist_pkg::*;
#(
  parameter int ADR_SIZE  = 4,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dir,
  input  logic [1:0]           mode,
  input  logic [DATA_SIZE-1:0] bg,
  input  logic                 inv,
  output logic                 rd_en,
  output logic [ADR_SIZE-1:0]  rd_adr,
  input  logic [DATA_SIZE-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 status,
  output logic [ADR_SIZE:0]    fail_cnt,
  output logic [ADR_SIZE-1:0]  fail_adr
);

  localparam logic [ADR_SIZE-1:0] ADR_ZERO = {ADR_SIZE{1'b0}};
  localparam logic [ADR_SIZE-1:0] ADR_ONE  = {{(ADR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADR_SIZE-1:0] ADR_MAX  = {ADR_SIZE{1'b1}};
  localparam logic [ADR_SIZE:0]   CNT_ZERO = {(ADR_SIZE+1){1'b0}};
  localparam logic [ADR_SIZE:0]   CNT_ONE  = {{ADR_SIZE{1'b0}}, 1'b1};

  state_t               state_r;
  logic                 dir_r;
  logic [1:0]           mode_r;
  logic [DATA_SIZE-1:0] bg_r;
  logic                 inv_r;
  logic                 pv_r;
  logic [ADR_SIZE-1:0]  pa_r;
  logic [DATA_SIZE-1:0] exp_s;
  logic                 mismatch_s;

  bist_exp_gen #(
    .ADR_SIZE (ADR_SIZE),
    .DATA_SIZE(DATA_SIZE)
  ) u_exp_gen (
    .mode    (mode_r),
    .bg      (bg_r),
    .inv     (inv_r),
    .adr     (pa_r),
    .exp_data(exp_s)
  );

  // Read data belongs to the address held in the compare stage; only meaningful when pv_r is set.
  assign mismatch_s = pv_r & (rd_data != exp_s);

  // Sequencer, compare pipeline and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      dir_r    <= 1'b0;
      mode_r   <= MODE_SOLID;
      bg_r     <= {DATA_SIZE{1'b0}};
      inv_r    <= 1'b0;
      pv_r     <= 1'b0;
      pa_r     <= ADR_ZERO;
      rd_en    <= 1'b0;
      rd_adr   <= ADR_ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
      status   <= 1'b1;
      fail_cnt <= CNT_ZERO;
      fail_adr <= ADR_ZERO;
    end else begin
      pv_r <= rd_en;
      pa_r <= rd_adr;
      done <= 1'b0;

      if (mismatch_s) begin
        if (fail_cnt == CNT_ZERO) begin
          fail_adr <= pa_r;
        end
        fail_cnt <= fail_cnt + CNT_ONE;
        status   <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            dir_r    <= dir;
            mode_r   <= mode;
            bg_r     <= bg;
            inv_r    <= inv;
            fail_cnt <= CNT_ZERO;
            fail_adr <= ADR_ZERO;
            status   <= 1'b1;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            rd_adr   <= dir ? ADR_MAX : ADR_ZERO;
            state_r  <= ST_READ;
          end
        end
        ST_READ: begin
          // Stop on the final address of the sweep; the address never wraps.
          if (rd_adr == (dir_r ? ADR_ZERO : ADR_MAX)) begin
            rd_en   <= 1'b0;
            state_r <= ST_DRAIN;
          end else begin
            rd_adr <= dir_r ? (rd_adr - ADR_ONE) : (rd_adr + ADR_ONE);
          end
        end
        ST_DRAIN: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
